sig_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one sigmoid engine (start/valid, variable latency) among N requesters.

---
 rtl/sig_rr_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_sig_rr_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_rr_scheduler.sv
// -----------------------------------------------------------------------------
// sig_rr_scheduler
//
// Shares one sigmoid engine among N requesters using round-robin arbitration.
// One operation is in flight at a time: an operand is accepted from the winning
// requester, handed to the engine, and the engine result (or a quiet NaN when
// the engine does not answer in time) is returned tagged with the requester id.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   req_valid    [N]          per-requester operand valid, held until accepted
//   req_data     [N*DWIDTH]   operands, requester i at [i*DWIDTH +: DWIDTH]
//   req_ready    [N]          one-hot, one-cycle accept pulse
//   rsp_valid    result valid, held until rsp_ready
//   rsp_ready    consumer accepts the result
//   rsp_id       [IDW]        requester owning rsp_data
//   rsp_data     [DWIDTH]     engine result, or 32'h7FC00000 after a timeout
//   eng_start    engine start, high for the whole engine operation
//   eng_x        [DWIDTH]     engine operand, stable while eng_start is high
//   eng_valid    engine result valid (only looked at while waiting)
//   eng_y        [DWIDTH]     engine result
//   busy         high whenever the FSM is not idle
//   err_clr      synchronous clear of timeout_err
//   timeout_err  sticky timeout flag
//
// Handshakes: a requester transfer happens in the cycle req_ready[i] is high
// (req_valid[i] is already high by then and must stay high until it is); the
// response transfer happens on the rising edge where rsp_valid && rsp_ready,
// and rsp_valid/rsp_id/rsp_data hold their values until that edge.
// -----------------------------------------------------------------------------
module sig_rr_scheduler #(
  parameter int N       = 4,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16,
  localparam int IDW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [N*DWIDTH-1:0]   req_data,
  output logic [N-1:0]          req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [DWIDTH-1:0]     rsp_data,
  output logic                  eng_start,
  output logic [DWIDTH-1:0]     eng_x,
  input  logic                  eng_valid,
  input  logic [DWIDTH-1:0]     eng_y,
  output logic                  busy,
  input  logic                  err_clr,
  output logic                  timeout_err
);

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [DWIDTH-1:0] QNAN       = DWIDTH'(32'h7FC0_0000);
  localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [IDW-1:0]    last_grant;
  logic [TW-1:0]     timer;

  // ---------------------------------------------------------------------------
  // Round-robin pick: search starts one past the last completed grant and
  // wraps, so the requester just served has the lowest priority next time.
  // ---------------------------------------------------------------------------
  logic              pick_found;
  logic [IDW-1:0]    pick_id;
  logic [N-1:0]      pick_onehot;
  logic [DWIDTH-1:0] pick_data;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && req_valid[(int'(last_grant) + k) % N]) begin
        pick_found = 1'b1;
        pick_id    = IDW'((int'(last_grant) + k) % N);
      end
    end
  end

  always_comb begin
    pick_onehot          = '0;
    pick_onehot[pick_id] = 1'b1;
  end

  assign pick_data = req_data[int'(pick_id) * DWIDTH +: DWIDTH];

  // Timeout fires on the last allowed WAIT cycle; an engine answer arriving in
  // that same cycle wins and no error is raised.
  logic timeout_hit;
  assign timeout_hit = (state == S_WAIT) && !eng_valid && (timer == TIMER_LAST);

  // ---------------------------------------------------------------------------
  // Main FSM. Every output is a register updated on the transition into the
  // state where it must be visible, so outputs never glitch combinationally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IDW'(N - 1);
      timer      <= '0;
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      eng_start  <= 1'b0;
      eng_x      <= '0;
      busy       <= 1'b0;
    end else begin
      // req_ready is a pulse: it only survives the single ISSUE cycle.
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            eng_x     <= pick_data;
            rsp_id    <= pick_id;
            req_ready <= pick_onehot;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            timer     <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (eng_valid) begin
            rsp_data  <= eng_y;
            rsp_valid <= 1'b1;
            eng_start <= 1'b0;
            state     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_data  <= QNAN;
            rsp_valid <= 1'b1;
            eng_start <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          // One idle cycle with eng_start low so the engine sees a clean
          // falling edge before the next operation.
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          req_ready <= '0;
          rsp_valid <= 1'b0;
          eng_start <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a timeout in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sig_rr_scheduler.sv
module tb_sig_rr_scheduler;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int IDW     = 2;
  localparam logic [DW-1:0] QNAN = 32'h7FC0_0000;

  // ---------------------------------------------------------------- signals
  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              eng_start;
  logic [DW-1:0]     eng_x;
  logic              eng_valid;
  logic [DW-1:0]     eng_y;
  logic              busy;
  logic              err_clr;
  logic              timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [IDW+DW-1:0] exp_q[$];
  logic [DW-1:0]     pend_data [N];
  int                eng_lat = 0;
  bit                exp_err = 1'b0;

  typedef struct {
    logic [N-1:0] raise;
    int           lat;
    int           rdy_wait;
    int           exp_id;
    bit           exp_to;
    bit           clr_hold;
  } vec_t;

  vec_t vecs [11];

  sig_rr_scheduler #(.N(N), .DWIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_valid   (eng_valid),
    .eng_y       (eng_y),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ------------------------------------------------------------- utilities
  function automatic logic [DW-1:0] eng_func(input logic [DW-1:0] x);
    if (x == 32'h3F80_0000) return 32'h3F3B_72AF;
    return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},   req_ready,   '0);
    check({tag, "_rsp_valid"},   rsp_valid,   '0);
    check({tag, "_rsp_id"},      rsp_id,      '0);
    check({tag, "_rsp_data"},    rsp_data,    '0);
    check({tag, "_eng_start"},   eng_start,   '0);
    check({tag, "_eng_x"},       eng_x,       '0);
    check({tag, "_busy"},        busy,        '0);
    check({tag, "_timeout_err"}, timeout_err, '0);
  endtask

  // ------------------------------------------------------------ engine model
  // Asserts eng_valid in the WAIT cycle whose timer equals eng_lat
  // (cycle count 1 = ISSUE, 2 = first WAIT cycle).
  initial begin
    int cnt;
    cnt       = 0;
    eng_valid = 1'b0;
    eng_y     = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_valid = 1'b0;
      eng_y     = $urandom;
      if (eng_start) begin
        cnt++;
        if (cnt == eng_lat + 2) begin
          eng_valid = 1'b1;
          eng_y     = eng_func(eng_x);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // -------------------------------------------------------------- scoreboard
  initial begin
    logic [IDW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_rsp: got id %0d data %0h, expected none", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_rsp_id",   rsp_id,   e[DW +: IDW]);
          check("sb_rsp_data", rsp_data, e[DW-1:0]);
        end
      end
    end
  end

  // ------------------------------------------------------------ driver task
  task automatic run_op(input string tag, input logic [N-1:0] raise, input int lat,
                        input int rdy_wait, input int exp_id, input bit exp_to,
                        input bit clr_hold, input logic [DW-1:0] x_fixed);
    int n;
    logic [N-1:0]  one;
    logic [N-1:0]  exp_grant;
    logic [DW-1:0] exp_data;
    for (int i = 0; i < N; i++) begin
      if (raise[i]) begin
        pend_data[i] = (x_fixed != '0) ? x_fixed : DW'($urandom);
        req_data[i*DW +: DW] = pend_data[i];
        req_valid[i] = 1'b1;
      end
    end
    eng_lat   = lat;
    rsp_ready = (rdy_wait == 0);
    one       = 1;
    exp_grant = one << exp_id;
    exp_data  = exp_to ? QNAN : eng_func(pend_data[exp_id]);
    exp_q.push_back({IDW'(exp_id), exp_data});
    if (exp_to) exp_err = 1'b1;

    n = 0;
    while (req_ready == '0 && n < 20) begin tick(); n++; end
    if (req_ready == '0) begin fail_now({tag, "_no_grant"}); return; end
    check({tag, "_grant"},  req_ready, exp_grant);
    check({tag, "_eng_x"},  eng_x, pend_data[exp_id]);
    check({tag, "_issue"},  {eng_start, busy}, 2'b11);
    req_valid = req_valid & ~exp_grant;
    if (clr_hold) err_clr = 1'b1;

    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
      if (clr_hold && n == 3) check({tag, "_err_cleared"}, timeout_err, 1'b0);
    end
    if (!rsp_valid) begin fail_now({tag, "_no_rsp"}); err_clr = 1'b0; return; end
    check({tag, "_latency"}, n, exp_to ? TIMEOUT + 1 : lat + 2);
    check({tag, "_resp_start"}, eng_start, 1'b0);
    if (exp_to) check({tag, "_err_set"}, timeout_err, 1'b1);
    err_clr = 1'b0;

    for (int k = 0; k < rdy_wait; k++) begin
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_id"},    rsp_id,    exp_id);
      check({tag, "_hold_data"},  rsp_data,  exp_data);
      check({tag, "_hold_ready"}, req_ready, '0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check({tag, "_rsp_drop"}, rsp_valid,   1'b0);
    check({tag, "_gap_busy"}, busy,        1'b1);
    check({tag, "_err"},      timeout_err, exp_err);
    tick();
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // ------------------------------------------------------------- main test
  initial begin
    int n;
    int order [8];
    logic [N-1:0] one;

    //              raise    lat  rdy  id  to  clr
    vecs[0]  = '{4'b1011,   0,   0,  3,  0,  0};
    vecs[1]  = '{4'b0000,   5,   0,  0,  0,  0};
    vecs[2]  = '{4'b0100,   1,   0,  1,  0,  0};
    vecs[3]  = '{4'b0000,   7,   0,  2,  0,  0};
    vecs[4]  = '{4'b1001,  15,   0,  3,  0,  0};
    vecs[5]  = '{4'b0000,  16,   0,  0,  1,  0};
    vecs[6]  = '{4'b0010,   2,  10,  1,  0,  0};
    vecs[7]  = '{4'b0101,   4,   0,  2,  0,  0};
    vecs[8]  = '{4'b0000,   0,   0,  0,  0,  0};
    vecs[9]  = '{4'b1000,  -1,   0,  3,  1,  0};
    vecs[10] = '{4'b0001, 1000,  0,  0,  1,  1};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    err_clr   = 1'b0;
    for (int i = 0; i < N; i++) pend_data[i] = '0;

    tick();
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Single request with a known operand/result pair.
    run_op("single", 4'b0100, 3, 0, 2, 1'b0, 1'b0, 32'h3F80_0000);

    // Table of operations; expected ids follow the rotating priority.
    for (int v = 0; v < 11; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].raise, vecs[v].lat, vecs[v].rdy_wait,
             vecs[v].exp_id, vecs[v].exp_to, vecs[v].clr_hold, '0);
    end

    // Sticky error persists until err_clr.
    for (int k = 0; k < 3; k++) begin
      check("sticky_err", timeout_err, 1'b1);
      tick();
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_clr", timeout_err, 1'b0);

    // Reset during WAIT abandons the operation.
    for (int i = 1; i < N; i += 2) begin
      pend_data[i] = $urandom;
      req_data[i*DW +: DW] = pend_data[i];
    end
    req_valid = 4'b1010;
    eng_lat   = 1000;
    n = 0;
    while (req_ready == '0 && n < 20) begin tick(); n++; end
    if (req_ready == '0) fail_now("rstmid_no_grant");
    check("rstmid_grant", req_ready, 4'b0010);
    req_valid = req_valid & ~req_ready;
    for (int k = 0; k < 5; k++) tick();
    check("rstmid_waiting", {eng_start, busy}, 2'b11);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    for (int i = 0; i < N; i++) begin
      pend_data[i] = $urandom;
      req_data[i*DW +: DW] = pend_data[i];
    end
    req_valid = '1;
    tick();
    tick();
    rst = 1'b0;

    // All requesters valid continuously: order 0,1,2,3 repeating.
    for (int k = 0; k < 8; k++) order[k] = k % N;
    one = 1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (req_ready == '0 && n < 40) begin tick(); n++; end
      if (req_ready == '0) begin fail_now("rr_no_grant"); break; end
      check($sformatf("rr_grant%0d", k), req_ready, one << order[k]);
      eng_lat = $urandom_range(0, 6);
      exp_q.push_back({IDW'(order[k]), eng_func(pend_data[order[k]])});
      if (k < 4) begin
        pend_data[order[k]] = $urandom;
        req_data[order[k]*DW +: DW] = pend_data[order[k]];
      end else begin
        req_valid[order[k]] = 1'b0;
      end
      tick();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 60) begin tick(); n++; end
    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_err", timeout_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
